// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding, bit counter width
// and the position of the R/W flag inside the address byte.
package i2c_pkg;

    localparam int unsigned BitCntW  = 3;
    localparam int unsigned RwBitPos = 0;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StRx,
        StRxAck,
        StTx,
        StTxAck,
        StWaitStop
    } state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA input synchronizers plus edge, START and STOP detection.
// All outputs are single-cycle pulses derived from the synchronized levels.
module i2c_line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;
    logic                   sda_s;

    // Reset to the idle-bus level so leaving reset never fakes an edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];
    assign sda_o      = sda_s;
    assign scl_rise_o = scl_s & ~scl_prev_q;
    assign scl_fall_o = ~scl_s & scl_prev_q;
    assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target (7-bit address) with byte-stream RX/TX handshake.
// Define I2C_CLK_STRETCH_EN to hold SCL low while waiting for read data.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = 7'h42,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       scl_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       busy
);

`ifdef I2C_CLK_STRETCH_EN
    localparam bit StretchEn = 1'b1;
`else
    localparam bit StretchEn = 1'b0;
`endif

    logic sda;
    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;

    i2c_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line_sync (
        .clk_i      (clk),
        .rst_i      (rst),
        .scl_i      (scl_in),
        .sda_i      (sda_in),
        .sda_o      (sda),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start),
        .stop_o     (stop)
    );

    state_e               state_q;
    logic [BitCntW-1:0]   bit_cnt_q;
    logic [6:0]           shift_q;
    logic                 rw_q;
    logic                 ack_on_q;
    logic [7:0]           tx_buf_q;
    logic                 tx_have_q;
    logic [6:0]           tx_shift_q;
    logic                 tx_loaded_q;
    logic                 tx_due_q;
    logic                 sda_oe_q;
    logic                 scl_oe_q;
    logic [7:0]           rx_data_q;
    logic                 rx_valid_q;
    logic                 tx_req_q;
    logic                 busy_q;

    logic [7:0] byte_in;
    logic [7:0] tx_src;
    logic       tx_ready;

    assign byte_in  = {shift_q, sda};
    assign tx_ready = tx_valid | tx_have_q;
    // A byte arriving this very cycle wins over the buffered one; nothing at all sends 0xFF.
    assign tx_src   = tx_valid ? tx_data : (tx_have_q ? tx_buf_q : 8'hFF);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rw_q        <= 1'b0;
            ack_on_q    <= 1'b0;
            tx_buf_q    <= '0;
            tx_have_q   <= 1'b0;
            tx_shift_q  <= '0;
            tx_loaded_q <= 1'b0;
            tx_due_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
            scl_oe_q    <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            if (tx_valid) begin
                tx_buf_q  <= tx_data;
                tx_have_q <= 1'b1;
            end

            if (start) begin
                state_q   <= StAddr;
                bit_cnt_q <= '0;
                ack_on_q  <= 1'b0;
                sda_oe_q  <= 1'b0;
                scl_oe_q  <= 1'b0;
                busy_q    <= 1'b0;
            end else if (stop) begin
                state_q  <= StIdle;
                sda_oe_q <= 1'b0;
                scl_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle, StWaitStop: begin
                    end

                    StAddr: begin
                        if (scl_rise) begin
                            shift_q   <= byte_in[6:0];
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == '1) begin
                                if (byte_in[7:1] == DEV_ADDR) begin
                                    state_q     <= StAddrAck;
                                    busy_q      <= 1'b1;
                                    ack_on_q    <= 1'b0;
                                    rw_q        <= byte_in[RwBitPos];
                                    // Ask for read data early so it is ready for the first bit.
                                    tx_req_q    <= byte_in[RwBitPos];
                                    tx_loaded_q <= 1'b0;
                                    tx_due_q    <= 1'b0;
                                end else begin
                                    state_q <= StWaitStop;
                                end
                            end
                        end
                    end

                    StAddrAck, StRxAck: begin
                        if (scl_fall) begin
                            if (!ack_on_q) begin
                                sda_oe_q <= 1'b1;
                                ack_on_q <= 1'b1;
                            end else begin
                                sda_oe_q  <= 1'b0;
                                ack_on_q  <= 1'b0;
                                bit_cnt_q <= '0;
                                if (state_q == StAddrAck && rw_q) begin
                                    // This fall is also the one that must present the first TX bit.
                                    state_q     <= StTx;
                                    tx_due_q    <= 1'b1;
                                    tx_loaded_q <= 1'b0;
                                end else begin
                                    state_q <= StRx;
                                end
                            end
                        end
                    end

                    StRx: begin
                        if (scl_rise) begin
                            shift_q   <= byte_in[6:0];
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == '1) begin
                                rx_data_q  <= byte_in;
                                rx_valid_q <= 1'b1;
                                ack_on_q   <= 1'b0;
                                state_q    <= StRxAck;
                            end
                        end
                    end

                    StTx: begin
                        if (!tx_loaded_q) begin
                            if (tx_due_q || scl_fall) begin
                                if (tx_ready || !StretchEn) begin
                                    sda_oe_q    <= ~tx_src[7];
                                    tx_shift_q  <= tx_src[6:0];
                                    bit_cnt_q   <= 3'd1;
                                    tx_loaded_q <= 1'b1;
                                    tx_due_q    <= 1'b0;
                                    tx_have_q   <= 1'b0;
                                    scl_oe_q    <= 1'b0;
                                end else begin
                                    scl_oe_q <= 1'b1;
                                    tx_due_q <= 1'b1;
                                end
                            end
                        end else if (scl_fall) begin
                            if (bit_cnt_q == '0) begin
                                sda_oe_q <= 1'b0;
                                state_q  <= StTxAck;
                            end else begin
                                sda_oe_q   <= ~tx_shift_q[6];
                                tx_shift_q <= {tx_shift_q[5:0], 1'b1};
                                bit_cnt_q  <= bit_cnt_q + 1'b1;
                            end
                        end
                    end

                    StTxAck: begin
                        if (scl_rise) begin
                            if (!sda) begin
                                tx_req_q    <= 1'b1;
                                tx_loaded_q <= 1'b0;
                                tx_due_q    <= 1'b0;
                                state_q     <= StTx;
                            end else begin
                                busy_q  <= 1'b0;
                                state_q <= StWaitStop;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign sda_oe   = sda_oe_q;
    assign scl_oe   = StretchEn ? scl_oe_q : 1'b0;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: bus-level controller model, randomized
// transfers and a transaction-level reference model of the expected outcome.
module tb_i2c_target;

    localparam logic [6:0] DevAddr = 7'h42;
    localparam int         H       = 12;
`ifdef I2C_CLK_STRETCH_EN
    localparam bit StretchModel = 1'b1;
`else
    localparam bit StretchModel = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_ctl, sda_ctl;
    logic       scl_in, sda_in;
    logic       sda_oe, scl_oe, rx_valid, tx_req, tx_valid, busy;
    logic [7:0] rx_data, tx_data;

    assign scl_in = scl_ctl & ~scl_oe;
    assign sda_in = sda_ctl & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target #(
        .DEV_ADDR    (DevAddr),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda_oe   (sda_oe),
        .scl_oe   (scl_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_req   (tx_req),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .busy     (busy)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Passive monitors
    int unsigned rxv_cnt = 0, txreq_cnt = 0, sdaoe_cnt = 0, scloe_cnt = 0, busy_cnt = 0;
    logic [7:0]  rx_log [$];
    always @(negedge clk) begin
        if (rx_valid) begin
            rxv_cnt++;
            rx_log.push_back(rx_data);
        end
        if (tx_req) txreq_cnt++;
        if (sda_oe) sdaoe_cnt++;
        if (scl_oe) scloe_cnt++;
        if (busy)   busy_cnt++;
    end

    // Read-data responder: answers each tx_req after tx_delay cycles.
    logic [7:0]  tx_mem [256];
    int unsigned tx_avail = 0, tx_served = 0, tx_delay = 0;
    initial begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (tx_req && tx_served < tx_avail) begin
                repeat (tx_delay) @(negedge clk);
                tx_data  = tx_mem[tx_served[7:0]];
                tx_valid = 1'b1;
                tx_served++;
                @(negedge clk);
                tx_valid = 1'b0;
            end
        end
    end

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: run exceeded cycle budget, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scl_release();
        int guard = 0;
        scl_ctl = 1'b1;
        while (scl_in !== 1'b1 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) check_eq("scl_release_timeout", {31'd0, scl_in}, 32'd1);
    endtask

    task automatic clock_bit(input logic b, output logic r);
        wait_clk(4);
        sda_ctl = b;
        wait_clk(H - 4);
        scl_release();
        wait_clk(H / 2);
        r = sda_in;
        wait_clk(H / 2);
        scl_ctl = 1'b0;
    endtask

    task automatic bus_start();
        sda_ctl = 1'b1;
        wait_clk(H);
        scl_release();
        wait_clk(H);
        sda_ctl = 1'b0;
        wait_clk(H);
        scl_ctl = 1'b0;
    endtask

    task automatic bus_stop();
        sda_ctl = 1'b0;
        wait_clk(H);
        scl_release();
        wait_clk(H);
        sda_ctl = 1'b1;
        wait_clk(H);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        logic r;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
        clock_bit(1'b1, r);
        acked = ~r;
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, r);
            b[i] = r;
        end
        clock_bit(~ack, r);
    endtask

    // Reference model: what the controller should observe for a read byte.
    function automatic logic [7:0] model_read_byte(input logic [7:0] supplied, input bit in_time);
        return (in_time || StretchModel) ? supplied : 8'hFF;
    endfunction

    logic [7:0] wr_buf [4];
    logic [7:0] rd_buf [4];

    task automatic run_write(input logic [6:0] addr, input int n, input bit do_stop);
        logic        ack;
        bit          match;
        int unsigned base_rx, base_sda, base_busy;
        match     = (addr == DevAddr);
        base_rx   = rx_log.size();
        base_sda  = sdaoe_cnt;
        base_busy = busy_cnt;
        bus_start();
        send_byte({addr, 1'b0}, ack);
        check_eq("wr_addr_ack", {31'd0, ack}, {31'd0, match});
        check_eq("wr_busy", {31'd0, busy}, {31'd0, match});
        for (int i = 0; i < n; i++) begin
            send_byte(wr_buf[i], ack);
            check_eq("wr_data_ack", {31'd0, ack}, {31'd0, match});
        end
        check_eq("wr_rx_count", rx_log.size() - base_rx, match ? n : 0);
        if (match) begin
            for (int i = 0; i < n; i++) check_eq("wr_rx_data", rx_log[base_rx + i], wr_buf[i]);
        end else begin
            check_eq("wr_sda_quiet", sdaoe_cnt - base_sda, 0);
            check_eq("wr_busy_quiet", busy_cnt - base_busy, 0);
        end
        if (do_stop) begin
            bus_stop();
            check_eq("wr_busy_after_stop", {31'd0, busy}, 0);
        end
    endtask

    task automatic run_read(input logic [6:0] addr, input int n, input int delay);
        logic        ack;
        logic [7:0]  got;
        bit          match;
        int unsigned base_req;
        match = (addr == DevAddr);
        if (match) begin
            for (int i = 0; i < n; i++) tx_mem[8'(tx_avail + i)] = rd_buf[i];
            tx_avail += n;
        end
        tx_delay = delay;
        base_req = txreq_cnt;
        bus_start();
        check_eq("rd_busy_after_start", {31'd0, busy}, 0);
        send_byte({addr, 1'b1}, ack);
        check_eq("rd_addr_ack", {31'd0, ack}, {31'd0, match});
        if (match) begin
            for (int i = 0; i < n; i++) begin
                recv_byte(i != n - 1, got);
                check_eq("rd_data", got, model_read_byte(rd_buf[i], delay <= 4));
            end
            check_eq("rd_busy_after_nack", {31'd0, busy}, 0);
        end
        check_eq("rd_tx_req_count", txreq_cnt - base_req, match ? n : 0);
        bus_stop();
        check_eq("rd_busy_after_stop", {31'd0, busy}, 0);
    endtask

    initial begin
        logic        ack, r;
        int unsigned base_rx, base_scl;
        logic [6:0]  addr;

        rst     = 1'b1;
        scl_ctl = 1'b1;
        sda_ctl = 1'b1;
        wait_clk(3);
        check_eq("rst_sda_oe", {31'd0, sda_oe}, 0);
        check_eq("rst_scl_oe", {31'd0, scl_oe}, 0);
        check_eq("rst_rx_data", rx_data, 0);
        check_eq("rst_rx_valid", {31'd0, rx_valid}, 0);
        check_eq("rst_tx_req", {31'd0, tx_req}, 0);
        check_eq("rst_busy", {31'd0, busy}, 0);
        rst = 1'b0;
        wait_clk(5);

        // Write 0xA5 to our address
        wr_buf[0] = 8'hA5;
        run_write(DevAddr, 1, 1'b1);
        // Foreign address is ignored
        wr_buf[0] = 8'h5A;
        run_write(7'h50, 1, 1'b1);
        // Two-byte read, controller ACKs then NACKs
        rd_buf[0] = 8'h3C;
        rd_buf[1] = 8'h7E;
        run_read(DevAddr, 2, 2);
        // Write, then repeated START into a read
        wr_buf[0] = 8'h11;
        run_write(DevAddr, 1, 1'b0);
        rd_buf[0] = 8'hC3;
        run_read(DevAddr, 1, 1);

        // Reset in the middle of a data byte
        base_rx = rx_log.size();
        bus_start();
        send_byte({DevAddr, 1'b0}, ack);
        check_eq("mid_rst_addr_ack", {31'd0, ack}, 1);
        for (int i = 0; i < 4; i++) clock_bit(1'b1, r);
        check_eq("mid_rst_busy_before", {31'd0, busy}, 1);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        check_eq("mid_rst_sda_oe", {31'd0, sda_oe}, 0);
        check_eq("mid_rst_scl_oe", {31'd0, scl_oe}, 0);
        check_eq("mid_rst_busy", {31'd0, busy}, 0);
        check_eq("mid_rst_no_rx", rx_log.size() - base_rx, 0);
        scl_ctl = 1'b1;
        wait_clk(H);
        sda_ctl = 1'b1;
        wait_clk(H);
        wr_buf[0] = 8'h96;
        run_write(DevAddr, 1, 1'b1);

        // Randomized transfers
        for (int t = 0; t < 16; t++) begin
            addr = ($urandom_range(0, 3) == 0) ? 7'($urandom) : DevAddr;
            for (int i = 0; i < 4; i++) begin
                wr_buf[i] = 8'($urandom);
                rd_buf[i] = 8'($urandom);
            end
            if ($urandom_range(0, 1) == 0) run_write(addr, int'($urandom_range(1, 3)), 1'b1);
            else run_read(addr, int'($urandom_range(1, 3)), int'($urandom_range(0, 4)));
        end

        // Late read data: stretched when enabled, otherwise 0xFF goes out
        base_scl  = scloe_cnt;
        rd_buf[0] = 8'h3C;
        run_read(DevAddr, 1, 200);
        if (StretchModel) check_eq("late_scl_stretched", {31'd0, (scloe_cnt - base_scl) > 100}, 1);
        else check_eq("late_scl_idle", scloe_cnt - base_scl, 0);
        wait_clk(250);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h42, giving the 7-bit target address that is matched.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the depth of the SCL/SDA input synchronizers (minimum 2).
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port scl_in, input, 1 bit: sampled SCL bus level.
REQ-006 SHALL have port sda_in, input, 1 bit: sampled SDA bus level.
REQ-007 SHALL have port sda_oe, output, 1 bit: 1 pulls SDA low (open-drain); 0 releases SDA.
REQ-008 SHALL have port scl_oe, output, 1 bit: 1 pulls SCL low for clock stretching.
REQ-009 SHALL have port rx_data, output, 8 bits: last byte written by the controller.
REQ-010 SHALL have port rx_valid, output, 1 bit: one-cycle strobe; rx_data is valid in that cycle.
REQ-011 SHALL have port tx_req, output, 1 bit: one-cycle strobe requesting the next read byte.
REQ-012 SHALL have port tx_data, input, 8 bits: byte to return to the controller; captured when tx_valid=1.
REQ-013 SHALL have port tx_valid, input, 1 bit: qualifies tx_data.
REQ-014 SHALL have port busy, output, 1 bit: high from an address match until STOP, repeated START, or NACK.

Function
REQ-015 SHALL pass scl_in and sda_in through SYNC_STAGES flops, then derive scl_rise, scl_fall, start (SDA falling while SCL high) and stop (SDA rising while SCL high), each as a one-cycle pulse.
REQ-016 SHALL implement states IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP.
REQ-017 SHALL, on start in any state, go to ADDR and clear the bit counter; start takes priority over every other event in the same cycle.
REQ-018 SHALL, on stop in any state, go to IDLE with sda_oe=0 and busy=0.
REQ-019 SHALL shift SDA in MSB-first on scl_rise; the 3-bit counter wraps 7->0 and the 8th bit completes a byte.
REQ-020 SHALL, in ADDR after 8 bits: if bits[7:1]==DEV_ADDR, go to ADDR_ACK and set busy; otherwise go to WAIT_STOP with SDA untouched.
REQ-021 SHALL assert sda_oe in ADDR_ACK and RX_ACK from the first scl_fall after the 8th bit until the next scl_fall (one full SCL period).
REQ-022 SHALL, after ADDR_ACK, go to RX when R/W=0, or to TX with tx_req pulsed when R/W=1.
REQ-023 SHALL pulse rx_valid for one clk cycle coincident with entry to RX_ACK, with rx_data updated in the same cycle; every received byte is ACKed.
REQ-024 SHALL, in TX, drive sda_oe=~bit on each scl_fall, MSB first, from the byte latched on tx_valid.
REQ-025 SHALL release SDA in TX_ACK and sample the controller's bit on scl_rise: 0 (ACK) -> pulse tx_req, return to TX; 1 (NACK) -> WAIT_STOP, busy=0.
REQ-026 SHALL, if tx_valid is not seen before the first TX scl_fall (without REQ-031), transmit 8'hFF.
REQ-027 SHALL treat a tx_valid outside the TX request window as the next byte, overwriting any unsent byte.

Reset
REQ-028 SHALL, while rst=1 at a clk edge, set state=IDLE, sda_oe=0, scl_oe=0, rx_data=8'h00, rx_valid=0, tx_req=0, busy=0, bit counter=0, and synchronizers to 1 (idle bus).
REQ-029 SHALL abandon any transfer when reset occurs mid-transfer, releasing both lines within the reset cycle; after reset it waits for a fresh start.

Configuration
REQ-030 SHALL use macro I2C_CLK_STRETCH_EN to enable clock stretching.
REQ-031 SHALL, with I2C_CLK_STRETCH_EN defined, assert scl_oe from the scl_fall that enters TX until tx_valid=1 is captured, then release it, so no 8'hFF substitution occurs.
REQ-032 SHALL, without I2C_CLK_STRETCH_EN, tie scl_oe to 0 and apply REQ-026.

Structure
REQ-033 SHALL define the state enumeration, the bit-count width and the R/W bit position constant in shared package i2c_pkg.
REQ-034 SHALL instantiate one sub-module, i2c_line_sync, holding the synchronizers and the edge/start/stop detectors of REQ-015.

Verification
REQ-035 SHALL cover: write 0x84 (addr 0x42, W), then 0xA5, then STOP -> ACK on both bytes, rx_valid once with rx_data=0xA5, busy falls on STOP.
REQ-036 SHALL cover: address 0x50 W -> no sda_oe at any time, no rx_valid, busy stays 0.
REQ-037 SHALL cover: read 0x85, tx_data=0x3C then 0x7E, controller ACKs byte 1 and NACKs byte 2 -> SDA bits 00111100 then 01111110, tx_req pulsed twice, WAIT_STOP.
REQ-038 SHALL cover: repeated START after a write byte, then 0x85 -> re-enter ADDR and transmit read data correctly.
REQ-039 SHALL cover: rst asserted mid-byte of a write -> sda_oe=0 and state IDLE on the next cycle; the next transfer succeeds.
REQ-040 SHALL cover: with I2C_CLK_STRETCH_EN, tx_valid delayed 200 cycles -> scl_oe=1 for that span, then 0x3C is sent; without the macro -> 0xFF is sent.
